// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet transmitter:
//   DATA_W / LEN_W / ADDR_W  - byte, length-field and address widths
//   BUF_DEPTH                - payload buffer depth (largest legal length)
//   ADDR_INVALID             - destination address that is always rejected
//   tx_state_e               - transmitter FSM states
//   build_header()           - header byte {len, addr}
// ----------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;
    localparam int ADDR_W    = 2;
    localparam int BUF_DEPTH = (1 << LEN_W) - 1;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
    localparam logic [LEN_W-1:0]  IDX_LIMIT    = LEN_W'(BUF_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY
    } tx_state_e;

    function automatic logic [DATA_W-1:0] build_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// ----------------------------------------------------------------------------
// router_tx_buf
// Payload store for the packet transmitter: BUF_DEPTH x DATA_W register
// array with one synchronous write port and one combinational read port.
// The read address comes from a registered index in the parent, so the
// read path is flop -> array mux.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write index
//   wr_data  in  write byte
//   rd_addr  in  read index
//   rd_data  out byte at rd_addr (zero for an out-of-range index)
// ----------------------------------------------------------------------------
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:BUF_DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < IDX_LIMIT)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The parent advances its read index one past the last byte after the
    // final payload beat is loaded; that index must not read beyond the array.
    always_comb begin
        rd_data = '0;
        if (rd_addr < IDX_LIMIT) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// ----------------------------------------------------------------------------
// router_pkt_tx
// Packet source for a 1x3 router input port. A request (addr, len) is
// accepted in IDLE, len payload bytes are collected into a local buffer,
// then the packet is sent as header {len,addr}, len payload bytes and a
// parity byte (XOR of header and payload). busy from the router stalls the
// transmit side; all outputs come straight from flops.
//
// Optional build macro ROUTER_TX_ERR_INJ_EN adds input err_inj, sampled at
// the request handshake; when set, the parity beat is inverted.
//
// Ports:
//   clk        in  clock (rising edge)
//   rst        in  synchronous active-high reset
//   req_valid  in  request valid          req_ready out high only in IDLE
//   req_addr   in  destination port       req_len   in  payload byte count
//   pl_valid   in  payload byte valid     pl_ready  out ready in LOAD
//   pl_data    in  payload byte
//   busy       in  router busy, stalls transmit beats
//   pkt_valid  out high for header/payload beats, low for parity
//   data_out   out byte to router
//   tx_done    out pulse when the parity beat is accepted
//   req_err    out pulse when a request is rejected
//   err_inj    in  (ROUTER_TX_ERR_INJ_EN only) corrupt this packet's parity
// ----------------------------------------------------------------------------
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
`ifdef ROUTER_TX_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done,
    output logic              req_err
);

    tx_state_e         state_q,     state_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] parity_q,    parity_d;
    logic [LEN_W-1:0]  wr_idx_q,    wr_idx_d;
    logic [LEN_W-1:0]  rd_idx_q,    rd_idx_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [DATA_W-1:0] data_out_q,  data_out_d;
    logic              tx_done_q,   tx_done_d;
    logic              req_err_q,   req_err_d;
    logic              pl_ready_q,  pl_ready_d;
    logic              req_ready_q, req_ready_d;

    logic              buf_we;
    logic [DATA_W-1:0] buf_rd_data;
    logic [DATA_W-1:0] parity_beat;

    router_tx_buf u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_idx_q),
        .wr_data (pl_data),
        .rd_addr (rd_idx_q),
        .rd_data (buf_rd_data)
    );

`ifdef ROUTER_TX_ERR_INJ_EN
    logic inj_q, inj_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    always_comb begin
        inj_d = inj_q;
        if ((state_q == ST_IDLE) && req_valid && req_ready_q) begin
            inj_d = err_inj;
        end
    end

    assign parity_beat = inj_q ? (parity_q ^ 8'hFF) : parity_q;
`else
    assign parity_beat = parity_q;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        parity_d    = parity_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        pkt_valid_d = pkt_valid_q;
        data_out_d  = data_out_q;
        tx_done_d   = 1'b0;
        req_err_d   = 1'b0;
        pl_ready_d  = pl_ready_q;
        req_ready_d = req_ready_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    len_d  = req_len;
                    addr_d = req_addr;
                    if ((req_len == '0) || (req_addr == ADDR_INVALID)) begin
                        req_err_d = 1'b1;
                    end else begin
                        state_d     = ST_LOAD;
                        req_ready_d = 1'b0;
                        pl_ready_d  = 1'b1;
                        parity_d    = build_header(req_len, req_addr);
                        wr_idx_d    = '0;
                    end
                end
            end

            ST_LOAD: begin
                if (pl_valid && pl_ready_q) begin
                    buf_we   = 1'b1;
                    wr_idx_d = wr_idx_q + LEN_W'(1);
                    parity_d = parity_q ^ pl_data;
                    // Last byte: the header is presented on the same edge.
                    if (wr_idx_q == (len_q - LEN_W'(1))) begin
                        pl_ready_d  = 1'b0;
                        state_d     = ST_HEADER;
                        pkt_valid_d = 1'b1;
                        data_out_d  = build_header(len_q, addr_q);
                        rd_idx_d    = '0;
                    end
                end
            end

            ST_HEADER: begin
                if (!busy) begin
                    state_d    = ST_PAYLOAD;
                    data_out_d = buf_rd_data;
                    rd_idx_d   = rd_idx_q + LEN_W'(1);
                end
            end

            ST_PAYLOAD: begin
                // rd_idx_q counts bytes already placed on data_out.
                if (!busy) begin
                    if (rd_idx_q == len_q) begin
                        state_d     = ST_PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = parity_beat;
                    end else begin
                        data_out_d = buf_rd_data;
                        rd_idx_d   = rd_idx_q + LEN_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (!busy) begin
                    tx_done_d   = 1'b1;
                    state_d     = ST_IDLE;
                    data_out_d  = '0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
                pl_ready_d  = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            parity_q    <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            tx_done_q   <= 1'b0;
            req_err_q   <= 1'b0;
            pl_ready_q  <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            parity_q    <= parity_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            tx_done_q   <= tx_done_d;
            req_err_q   <= req_err_d;
            pl_ready_q  <= pl_ready_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign pl_ready  = pl_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign tx_done   = tx_done_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// ----------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed and randomized packets for router_pkt_tx. The expected beat
// stream of each packet is built from the packet rules (header = len*4+addr,
// payload in order, parity = XOR of everything sent) and compared beat by
// beat while busy is driven directed or random.
// ----------------------------------------------------------------------------
module tb_router_pkt_tx;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_err;
`ifdef ROUTER_TX_ERR_INJ_EN
    logic       err_inj;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] pay [0:62];
    logic [7:0] exp_q [$];
    bit         exp_v [$];

    router_pkt_tx dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
`ifdef ROUTER_TX_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    // Reference beat stream for one packet.
    task automatic build_expect(input int addr, input int len, input bit inj);
        logic [7:0] hdr;
        logic [7:0] p;
        exp_q.delete();
        exp_v.delete();
        hdr = 8'(len * 4 + addr);
        p   = hdr;
        exp_q.push_back(hdr);
        exp_v.push_back(1'b1);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            exp_v.push_back(1'b1);
            p = p ^ pay[i];
        end
        if (inj) p = p ^ 8'hFF;
        exp_q.push_back(p);
        exp_v.push_back(1'b0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pkt_valid"}, {7'b0, pkt_valid}, 8'h00);
        chk({tag, "_data_out"},  data_out,          8'h00);
        chk({tag, "_req_ready"}, {7'b0, req_ready}, 8'h01);
        chk({tag, "_pl_ready"},  {7'b0, pl_ready},  8'h00);
        chk({tag, "_tx_done"},   {7'b0, tx_done},   8'h00);
        chk({tag, "_req_err"},   {7'b0, req_err},   8'h00);
    endtask

    // Returns 1 when the request should have been accepted.
    task automatic do_req(input int addr, input int len, input bit inj, output bit ok);
        chk("req_ready_before", {7'b0, req_ready}, 8'h01);
        req_valid = 1'b1;
        req_addr  = 2'(addr);
        req_len   = 6'(len);
`ifdef ROUTER_TX_ERR_INJ_EN
        err_inj   = inj;
`else
        if (inj) $display("note: err_inj ignored in this build");
`endif
        @(negedge clk);
        req_valid = 1'b0;
        ok = !(len == 0 || addr == 3);
        if (!ok) begin
            chk("rej_req_err",   {7'b0, req_err},   8'h01);
            chk("rej_pl_ready",  {7'b0, pl_ready},  8'h00);
            chk("rej_pkt_valid", {7'b0, pkt_valid}, 8'h00);
            chk("rej_req_ready", {7'b0, req_ready}, 8'h01);
            @(negedge clk);
            chk("rej_err_pulse", {7'b0, req_err},   8'h00);
            chk("rej_pl_ready2", {7'b0, pl_ready},  8'h00);
        end else begin
            chk("acc_req_err",   {7'b0, req_err},   8'h00);
            chk("acc_req_ready", {7'b0, req_ready}, 8'h00);
        end
    endtask

    // Feed len payload bytes, with optional idle gaps and ignored busy noise.
    task automatic load_payload(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    busy     = 1'($urandom_range(0, 1));
                    pl_valid = 1'b0;
                    chk("load_gap_pl_ready", {7'b0, pl_ready}, 8'h01);
                    @(negedge clk);
                end
            end
            chk("load_pl_ready", {7'b0, pl_ready}, 8'h01);
            chk("load_pkt_valid", {7'b0, pkt_valid}, 8'h00);
            pl_valid = 1'b1;
            pl_data  = pay[i];
            @(negedge clk);
            pl_valid = 1'b0;
        end
        busy = 1'b0;
        chk("load_done_pl_ready", {7'b0, pl_ready}, 8'h00);
    endtask

    // mode 0: no busy, 1: random busy, 2: 3-cycle stall on beat 3.
    // Stops without consuming beat abort_at when abort_at >= 0.
    task automatic run_tx(input int mode, input int abort_at);
        int  k     = 0;
        int  stall = 3;
        bit  b;
        while (k < exp_q.size()) begin
            chk($sformatf("beat%0d_data", k), data_out, exp_q[k]);
            chk($sformatf("beat%0d_valid", k), {7'b0, pkt_valid}, {7'b0, exp_v[k]});
            chk("beat_tx_done_low", {7'b0, tx_done}, 8'h00);
            if (k == abort_at) return;
            b = 1'b0;
            if (mode == 1) b = ($urandom_range(0, 3) == 0);
            if (mode == 2 && k == 3 && stall > 0) begin
                b = 1'b1;
                stall--;
            end
            busy = b;
            @(negedge clk);
            if (!b) k++;
        end
        busy = 1'b0;
        chk("done_tx_done",   {7'b0, tx_done},   8'h01);
        chk("done_data_out",  data_out,          8'h00);
        chk("done_req_ready", {7'b0, req_ready}, 8'h01);
        chk("done_pkt_valid", {7'b0, pkt_valid}, 8'h00);
        @(negedge clk);
        chk("done_pulse_end", {7'b0, tx_done},   8'h00);
    endtask

    task automatic send_pkt(input int addr, input int len, input bit inj,
                            input int mode, input bit gaps, input int abort_at);
        bit ok;
        do_req(addr, len, inj, ok);
        if (ok) begin
            build_expect(addr, len, inj);
            load_payload(len, gaps);
            run_tx(mode, abort_at);
        end
        $display("pkt addr=%0d len=%0d inj=%0d mode=%0d ok=%0d total=%0d bad=%0d",
                 addr, len, inj, mode, ok, total, bad);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        pl_valid  = 1'b0;
        busy      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        pl_valid  = 1'b0;
        pl_data   = '0;
        busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
        err_inj   = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        $display("reset checked total=%0d bad=%0d", total, bad);

        // Good packet: addr 2, len 5, bytes 01..05.
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
        send_pkt(2, 5, 1'b0, 0, 1'b0, -1);

        // Same packet with a 3-cycle stall on the byte 03 beat.
        send_pkt(2, 5, 1'b0, 2, 1'b0, -1);

        // Rejected requests.
        send_pkt(1, 0, 1'b0, 0, 1'b0, -1);
        send_pkt(3, 4, 1'b0, 0, 1'b0, -1);

        // Full-depth packet.
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        send_pkt(2, 63, 1'b0, 0, 1'b0, -1);

        // Reset while payload byte 03 is on the bus.
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
        send_pkt(1, 5, 1'b0, 0, 1'b0, 3);
        do_reset();
        check_idle("midrst");
        $display("mid-payload reset checked total=%0d bad=%0d", total, bad);
        for (int i = 0; i < 7; i++) pay[i] = 8'($urandom_range(0, 255));
        send_pkt(0, 7, 1'b0, 0, 1'b0, -1);

`ifdef ROUTER_TX_ERR_INJ_EN
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
        send_pkt(2, 5, 1'b1, 0, 1'b0, -1);
        send_pkt(2, 5, 1'b0, 0, 1'b0, -1);
`endif

        // Randomized packets, including occasional invalid requests.
        for (int n = 0; n < 14; n++) begin
            int a = $urandom_range(0, 3);
            int l = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 63);
            for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(0, 255));
            send_pkt(a, l, 1'b0, 1, 1'b1, -1);
        end

        @(negedge clk);
        check_idle("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
